// File: rtl/ring_osc_cal_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ring_osc_cal_pkg
//  Description : Shared types, constants and the index-to-trim thermometer
//                mapping for the ring-oscillator trim calibrator.
//  Revision    : 1.0 - initial release
// ============================================================================
package ring_osc_cal_pkg;

    localparam int TRIM_W       = 26;
    localparam int TRIM_IDX_MAX = 26;
    localparam int TRIM_IDX_W   = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        MEASURE = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4,
        FAIL    = 3'd5
    } cal_state_t;

    // Index k sets the low k bits of the bus; primary bits [12:0] fill
    // first, then secondary bits [25:13], so each step slows the ring a bit.
    function automatic logic [TRIM_W-1:0] idx_to_trim(input logic [TRIM_IDX_W-1:0] idx);
        logic [TRIM_W-1:0] v;
        v = '0;
        for (int i = 0; i < TRIM_W; i++) begin
            v[i] = (i < int'(idx));
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ring_osc_edge_counter.sv
`default_nettype none
// ============================================================================
//  Module      : ring_osc_edge_counter
//  Description : Synchronizes the divided oscillator clock, detects its
//                rising edges and counts them over a window of clk cycles.
//                result_valid is asserted combinationally in the last window
//                cycle so that cycle's edge is part of the reported result.
//  Revision    : 1.0 - initial release
// ============================================================================
module ring_osc_edge_counter #(
    parameter int CNT_W       = 16,
    parameter int WIN_W       = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             osc_div,
    input  logic             clear,
    input  logic             go,
    input  logic [WIN_W-1:0] window_len,
    output logic             result_valid,
    output logic [CNT_W-1:0] result
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_prev;
    logic                   w_rise;
    logic [CNT_W-1:0]       r_edge_cnt;
    logic [CNT_W-1:0]       w_cnt_next;
    logic [WIN_W-1:0]       r_timer;
    logic                   r_active;

    // Bring osc_div into the clk domain and keep one extra stage for edge detect
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_sync      <= '0;
            r_sync_prev <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], osc_div};
            r_sync_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_rise     = r_sync[SYNC_STAGES-1] & ~r_sync_prev;
    assign w_cnt_next = (w_rise && (r_edge_cnt != {CNT_W{1'b1}})) ? (r_edge_cnt + 1'b1) : r_edge_cnt;

    // Saturating edge counter, only advancing while the window is open
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_edge_cnt <= '0;
        end else if (clear) begin
            r_edge_cnt <= '0;
        end else if (r_active) begin
            r_edge_cnt <= w_cnt_next;
        end
    end

    // Window timer: open for window_len cycles starting the cycle after go
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_active <= 1'b0;
            r_timer  <= '0;
        end else if (go) begin
            r_active <= 1'b1;
            r_timer  <= window_len - 1'b1;
        end else if (r_active) begin
            if (r_timer == '0) begin
                r_active <= 1'b0;
            end else begin
                r_timer <= r_timer - 1'b1;
            end
        end
    end

    assign result_valid = r_active && (r_timer == '0);
    assign result       = w_cnt_next;

endmodule
`default_nettype wire

// File: rtl/ring_osc_trim_cal.sv
`default_nettype none
// ============================================================================
//  Module      : ring_osc_trim_cal
//  Description : Closed-loop trim calibrator for the 13-stage ring
//                oscillator. Walks the trim index from fastest (0) toward
//                slowest (26), measuring the divided-clock edge count per
//                window after each step, until the count drops into band.
//  Revision    : 1.0 - initial release
// ============================================================================
module ring_osc_trim_cal
    import ring_osc_cal_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int WIN_W       = 12,
    parameter int SETTLE_CYC  = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  start,
    input  logic [WIN_W-1:0]      window,
    input  logic [CNT_W-1:0]      target,
    input  logic [CNT_W-1:0]      tol,
    input  logic                  osc_div,
    output logic [TRIM_W-1:0]     trim,
    output logic [TRIM_IDX_W-1:0] trim_idx,
    output logic [CNT_W-1:0]      count,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int                     SETTLE_W      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SETTLE_W-1:0]    C_SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [TRIM_IDX_W-1:0]  C_IDX_MAX     = TRIM_IDX_W'(TRIM_IDX_MAX);

    cal_state_t              r_state;
    logic [TRIM_IDX_W-1:0]   r_trim_idx;
    logic [TRIM_W-1:0]       r_trim;
    logic [CNT_W-1:0]        r_count;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_err;
    logic [SETTLE_W-1:0]     r_settle_cnt;
    logic [WIN_W-1:0]        r_window;
    logic [CNT_W-1:0]        r_band_lo;
    logic [CNT_W-1:0]        r_band_hi;

    logic [CNT_W:0]          w_hi_sum;
    logic [CNT_W-1:0]        w_band_lo;
    logic [CNT_W-1:0]        w_band_hi;
    logic [WIN_W-1:0]        w_window_eff;
    logic                    w_launch;
    logic                    w_result_valid;
    logic [CNT_W-1:0]        w_result;

    // Pass band edges clamp at 0 and at full scale instead of wrapping
    assign w_hi_sum     = {1'b0, target} + {1'b0, tol};
    assign w_band_hi    = w_hi_sum[CNT_W] ? {CNT_W{1'b1}} : w_hi_sum[CNT_W-1:0];
    assign w_band_lo    = (target > tol) ? (target - tol) : '0;
    assign w_window_eff = (window == '0) ? WIN_W'(1) : window;

    // Last settle cycle: clear the counter and open the window together
    assign w_launch = (r_state == SETTLE) && (r_settle_cnt == C_SETTLE_LAST);

    ring_osc_edge_counter #(
        .CNT_W       (CNT_W),
        .WIN_W       (WIN_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_counter (
        .clk          (clk),
        .resetb       (resetb),
        .osc_div      (osc_div),
        .clear        (w_launch),
        .go           (w_launch),
        .window_len   (r_window),
        .result_valid (w_result_valid),
        .result       (w_result)
    );

    // Calibration sequencer with registered status outputs
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state      <= IDLE;
            r_trim_idx   <= '0;
            r_count      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_settle_cnt <= '0;
            r_window     <= WIN_W'(1);
            r_band_lo    <= '0;
            r_band_hi    <= '0;
        end else begin
            case (r_state)
                IDLE, DONE, FAIL: begin
                    if (start) begin
                        r_trim_idx   <= '0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_err        <= 1'b0;
                        r_settle_cnt <= '0;
                        r_window     <= w_window_eff;
                        r_band_lo    <= w_band_lo;
                        r_band_hi    <= w_band_hi;
                        r_state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (r_settle_cnt == C_SETTLE_LAST) begin
                        r_settle_cnt <= '0;
                        r_state      <= MEASURE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                MEASURE: begin
                    if (w_result_valid) begin
                        r_count <= w_result;
                        r_state <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (r_count > r_band_hi) begin
                        if (r_trim_idx == C_IDX_MAX) begin
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                            r_state <= FAIL;
                        end else begin
                            r_trim_idx <= r_trim_idx + 1'b1;
                            r_state    <= SETTLE;
                        end
                    end else if ((r_count >= r_band_lo) || (r_trim_idx != '0)) begin
                        // Below band after stepping means the previous step
                        // overshot; keep the current index as the answer.
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= FAIL;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Trim bus follows the index one clock later through the thermometer map
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_trim <= '0;
        end else begin
            r_trim <= idx_to_trim(r_trim_idx);
        end
    end

    assign trim     = r_trim;
    assign trim_idx = r_trim_idx;
    assign count    = r_count;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ring_osc_trim_cal.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ring_osc_trim_cal
//  Description : Testbench for ring_osc_trim_cal. An oscillator model emits
//                a chosen number of osc_div edges inside each measurement
//                window, keyed on the trim code it is driven with; a
//                reference model derives the expected end result per run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_osc_trim_cal;

    localparam int S = 64;

    logic        clk = 1'b0;
    logic        resetb;
    logic        start;
    logic [11:0] window;
    logic [15:0] target;
    logic [15:0] tol;
    logic        osc_div;
    logic [25:0] trim;
    logic [4:0]  trim_idx;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic        err;

    ring_osc_trim_cal #(
        .CNT_W       (16),
        .WIN_W       (12),
        .SETTLE_CYC  (S),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .resetb   (resetb),
        .start    (start),
        .window   (window),
        .target   (target),
        .tol      (tol),
        .osc_div  (osc_div),
        .trim     (trim),
        .trim_idx (trim_idx),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        d;
        logic        e;
        int          idx;
        logic [25:0] trim;
        int          cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    int   edge_tab[27];
    int   osc_mode  = 0;   // 0: edges from table, 1: held high, 2: window probe
    int   probe_ph  = 0;
    int   run_start = 32'h3fff_ffff;
    int   run_len   = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, expv);
        end
    endtask

    // Oscillator model: in step k of a run, emit edge_tab[k] rising edges,
    // one every two clocks, well inside that step's measurement window.
    always @(negedge clk) begin : osc_model
        int rel;
        int off;
        int c;
        rel = cyc - run_start;
        if (osc_mode == 1) begin
            osc_div = 1'b1;
        end else if (rel < 0) begin
            osc_div = 1'b0;
        end else if (osc_mode == 2) begin
            osc_div = (rel == S - 4 + probe_ph) || (rel == S - 2 + probe_ph) || (rel == S + probe_ph);
        end else begin
            off = rel % run_len;
            c   = edge_tab[$countones(trim)];
            osc_div = (off >= S + 3) && (off < S + 3 + 2 * c) && (((off - (S + 3)) % 2) == 0);
        end
    end

    // Reference: walk indices 0..26 applying the band rules to the table
    function automatic exp_t model(input int tgt, input int tl);
        exp_t        r;
        int          lo;
        int          hi;
        int          k;
        int          c;
        bit          fin;
        logic [63:0] t;
        lo = tgt - tl;
        if (lo < 0) lo = 0;
        hi = tgt + tl;
        if (hi > 65535) hi = 65535;
        k   = 0;
        c   = 0;
        fin = 1'b0;
        r.d = 1'b0;
        r.e = 1'b0;
        while (!fin) begin
            c = edge_tab[k];
            if (c > 65535) c = 65535;
            if (c > hi) begin
                if (k == 26) begin
                    r.e = 1'b1;
                    fin = 1'b1;
                end else begin
                    k++;
                end
            end else if (c >= lo || k > 0) begin
                r.d = 1'b1;
                fin = 1'b1;
            end else begin
                r.e = 1'b1;
                fin = 1'b1;
            end
        end
        r.idx  = k;
        t      = (64'd1 << k) - 64'd1;
        r.trim = t[25:0];
        r.cnt  = c;
        return r;
    endfunction

    // Monitor: each completion pops one expectation and compares outputs
    always @(negedge clk) begin : monitor
        logic fin_now;
        logic prev_fin;
        exp_t e;
        fin_now = done | err;
        if (!resetb) begin
            prev_fin = 1'b0;
        end else begin
            if (fin_now && !prev_fin) begin
                chk("completion_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("done",     done,     e.d);
                    chk("err",      err,      e.e);
                    chk("trim_idx", trim_idx, e.idx);
                    chk("trim",     trim,     e.trim);
                    chk("count",    count,    e.cnt);
                    chk("busy_end", busy,     0);
                end
            end
            prev_fin = fin_now;
        end
    end

    task automatic run_cal(input int win, input int tgt, input int tl, input bit expect_result);
        @(negedge clk);
        window    = 12'(win);
        target    = 16'(tgt);
        tol       = 16'(tl);
        start     = 1'b1;
        run_len   = S + ((win == 0) ? 1 : win) + 1;
        run_start = cyc + 1;
        if (expect_result) exp_q.push_back(model(tgt, tl));
        @(negedge clk);
        start = 1'b0;
        chk("start_busy",    busy, 1);
        chk("start_done_lo", done, 0);
        chk("start_err_lo",  err,  0);
        // Inputs must be held internally; disturb them for the rest of the run
        window = 12'($urandom);
        target = 16'($urandom);
        tol    = 16'($urandom);
    endtask

    task automatic wait_fin(input int limit);
        int n;
        n = 0;
        while (!(done || err) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("run_finished", done || err, 1);
    endtask

    initial begin
        int base;
        int slope;
        int tgt;
        int tl;
        int win;
        resetb  = 1'b0;
        start   = 1'b0;
        window  = '0;
        target  = '0;
        tol     = '0;
        for (int k = 0; k < 27; k++) edge_tab[k] = 0;
        repeat (3) @(negedge clk);
        chk("rst_trim",     trim,     0);
        chk("rst_trim_idx", trim_idx, 0);
        chk("rst_count",    count,    0);
        chk("rst_busy",     busy,     0);
        chk("rst_done",     done,     0);
        chk("rst_err",      err,      0);
        resetb = 1'b1;
        repeat (2) @(negedge clk);

        // Linear model 100-3k: lands at k=10
        for (int k = 0; k < 27; k++) edge_tab[k] = 100 - 3 * k;
        run_cal(256, 70, 2, 1);
        wait_fin(27 * (S + 257) + 50);

        // Too slow at fastest setting
        for (int k = 0; k < 27; k++) edge_tab[k] = 40;
        run_cal(256, 70, 2, 1);
        wait_fin(27 * (S + 257) + 50);

        // Upper band edge clamps at full scale
        run_cal(256, 65530, 10, 1);
        wait_fin(27 * (S + 257) + 50);

        // Too fast even at slowest setting
        for (int k = 0; k < 27; k++) edge_tab[k] = 200;
        run_cal(512, 70, 2, 1);
        wait_fin(27 * (S + 513) + 50);

        // Overshoot between k=14 and k=15 keeps k=15
        for (int k = 0; k < 27; k++) edge_tab[k] = (k < 14) ? 100 : (k == 14) ? 80 : (k == 15) ? 60 : 50;
        run_cal(256, 70, 2, 1);
        wait_fin(27 * (S + 257) + 50);

        // start during MEASURE is ignored; exactly one completion
        for (int k = 0; k < 27; k++) edge_tab[k] = 100 - 3 * k;
        run_cal(256, 70, 2, 1);
        repeat (S + 20) @(negedge clk);
        window = 12'd5;
        target = 16'd100;
        tol    = 16'd0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_ignored_start", busy, 1);
        wait_fin(27 * (S + 257) + 50);
        repeat (20) @(negedge clk);
        chk("no_restart_busy", busy, 0);
        chk("no_restart_done", done, 1);

        // Asynchronous reset during the second step's settle
        run_cal(256, 70, 2, 0);
        repeat (S + 257 + 5) @(negedge clk);
        chk("pre_rst_trim_idx", trim_idx, 1);
        chk("pre_rst_trim",     trim,     1);
        #2 resetb = 1'b0;
        #1;
        chk("async_rst_trim",     trim,     0);
        chk("async_rst_busy",     busy,     0);
        chk("async_rst_done",     done,     0);
        chk("async_rst_trim_idx", trim_idx, 0);
        @(negedge clk);
        resetb = 1'b1;
        repeat (2) @(negedge clk);

        // osc_div held high: no edges; lower band edge clamps at 0
        osc_mode = 1;
        for (int k = 0; k < 27; k++) edge_tab[k] = 0;
        repeat (10) @(negedge clk);
        run_cal(256, 3, 5, 1);
        wait_fin(27 * (S + 257) + 50);
        osc_mode = 0;
        repeat (10) @(negedge clk);

        // window=0 measures exactly one cycle: phase A catches one edge
        osc_mode = 2;
        probe_ph = 0;
        edge_tab[0] = 1;
        run_cal(0, 1, 0, 1);
        wait_fin(27 * (S + 2) + 50);
        repeat (10) @(negedge clk);
        // phase B edges fall just outside the one-cycle window
        probe_ph = 1;
        edge_tab[0] = 0;
        run_cal(0, 1, 0, 1);
        wait_fin(27 * (S + 2) + 50);
        osc_mode = 0;
        repeat (10) @(negedge clk);

        // Randomized descending tables and bands
        for (int r = 0; r < 3; r++) begin
            base  = $urandom_range(150, 60);
            slope = $urandom_range(8, 2);
            for (int k = 0; k < 27; k++) edge_tab[k] = (base - slope * k > 0) ? base - slope * k : 0;
            tgt = $urandom_range(150, 0);
            tl  = $urandom_range(5, 0);
            win = 2 * base + 4 + $urandom_range(40, 0);
            run_cal(win, tgt, tl, 1);
            wait_fin(27 * (S + win + 1) + 50);
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ring_osc_trim_cal.md
Name: ring_osc_trim_cal

Overview:
- Closed-loop trim calibrator for the 13-stage tunable ring oscillator. It consumes the oscillator output and drives the oscillator's 26-bit trim bus.
- It counts rising edges of a divided oscillator clock over a programmable window of system clocks. It then steps the trim code from fastest to slower until the measured count falls to the target band.
- It sits in the housekeeping/clocking domain, beside the oscillator and the DLL control logic.

Parameters:
- CNT_W, 16, width of edge counter, target and tolerance compare.
- WIN_W, 12, width of the window-length input, in system clock cycles.
- SETTLE_CYC, 64, system clocks to wait after each trim change before measuring.
- SYNC_STAGES, 2, flops in the osc_div synchronizer (minimum 2).

Ports:
- clk  in  1  system clock, independent of the oscillator.
- resetb  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a calibration run.
- window  in  WIN_W  measurement window in clk cycles; 0 is treated as 1.
- target  in  CNT_W  desired osc_div rising-edge count per window.
- tol  in  CNT_W  band half-width; the pass band is [target-tol, target+tol], saturating at 0 and at max.
- osc_div  in  1  oscillator clock divided down (e.g. /16) in the oscillator domain; asynchronous to clk.
- trim  out  26  trim bus to the oscillator: [12:0] primary bits, [25:13] secondary bits.
- trim_idx  out  5  current trim index, 0..26.
- count  out  CNT_W  edge count from the last completed window.
- busy  out  1  high from an accepted start until DONE or FAIL.
- done  out  1  level; high in DONE and cleared on the next accepted start.
- err  out  1  level; high in FAIL and cleared on the next accepted start.

Behaviour:
- Reset values: trim=0, trim_idx=0, count=0, busy=0, done=0, err=0, state=IDLE, synchronizer flops=0.
- Index-to-trim mapping (thermometer, primary bits first). The mapping is registered, so trim changes one clk after trim_idx changes.
  - k<=13: trim[k-1:0]=1 and all other bits 0.
  - k>13: trim[12:0]=all 1, trim[12+(k-13):13]=1, and the remaining upper bits 0.
  - k=26: all 26 bits are 1.
- osc_div passes through SYNC_STAGES flops. One extra flop provides rising-edge detect, giving one increment per synchronized 0->1 transition.
- Edge counter saturates at 2^CNT_W-1.
- FSM states:
  - IDLE: start -> SETTLE, with trim_idx=0, busy=1, done=0, err=0.
  - SETTLE: wait SETTLE_CYC clocks, then clear the edge counter -> MEASURE.
  - MEASURE: count edges for max(window,1) clocks. The edge detect in the final window cycle is included. Latch the result into count -> COMPARE.
  - COMPARE (1 cycle):
    - count > target+tol and trim_idx<26: trim_idx+1 -> SETTLE.
    - count > target+tol and trim_idx==26: -> FAIL (too fast even at slowest setting).
    - count >= target-tol: -> DONE.
    - count < target-tol: if trim_idx==0 -> FAIL (too slow at fastest setting); else -> DONE. The earlier step already overshot, so the current index is kept.
  - DONE: busy=0, done=1; trim holds. start -> SETTLE with trim_idx reset to 0.
  - FAIL: busy=0, err=1; trim holds the last tried code. start behaves as in DONE.
- start while busy is ignored, with no restart.
- start and a COMPARE decision in the same cycle: the FSM takes the COMPARE transition and drops start.
- window, target and tol are sampled in the accepted-start cycle and held internally for the whole run.
- Asynchronous resetb assertion mid-run returns all outputs to their reset values immediately. The oscillator therefore returns to its fastest setting (trim=0).
- Per-step latency: SETTLE_CYC + max(window,1) + 1 (COMPARE) clocks.

Decomposition:
- Shared package ring_osc_cal_pkg: state enum (IDLE, SETTLE, MEASURE, COMPARE, DONE, FAIL), TRIM_W=26, TRIM_IDX_MAX=26, and the index-to-thermometer function.
- One natural sub-module: ring_osc_edge_counter. It holds the synchronizer, edge detect, saturating counter and window timer, with a clear/go interface and a result-valid strobe back to the FSM.

Test Plan:
- Model edge count as 100 - 3*k for index k; window=256, target=70, tol=2, start -> done=1, trim_idx=10, trim=26'h00003FF, count=70, err=0.
- Model edge count as 40 for every k; target=70, tol=2 -> err=1, done=0, trim_idx=0, trim=0, count=40.
- Model edge count as 200 for every k; target=70 -> 26 steps, then err=1, trim_idx=26, trim=26'h3FFFFFF.
- Model edge count 80 at k=14 and 60 at k=15; target=70, tol=2 -> done=1, trim_idx=15, trim=26'h0003FFF|(1<<13)|(1<<14).
- start pulsed during MEASURE is ignored, with a single run; then resetb low mid-SETTLE -> trim=0, busy=0, done=0 within the same cycle.
- osc_div held high throughout -> count=0 (no edges); window=0 measures exactly 1 cycle.
